idu: RTL and testbench



---
 rtl/idu_if.sv | 34 +++
 rtl/idu.sv | 135 +++++++++++++
 tb/tb_idu.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/idu_if.sv
// Fetch->decode and decode->ALU handshake bundle for the instruction decode unit.
// The slave modport is the decode side; the master modport is the surrounding fetch/ALU environment.
interface idu_if #(
  parameter int PC_WIDTH  = 32,
  parameter int IMM_WIDTH = 32
);
  logic                 ifu_idu_vld;
  logic [63:0]          ifu_idu_ins;
  logic [PC_WIDTH-1:0]  ifu_idu_pc;
  logic                 idu_ifu_rdy;
  logic                 idu_ifu_wfi;
  logic                 alu_idu_br_vld;
  logic                 idu_alu_rdy;
  logic                 idu_alu_vld;
  logic [5:0]           idu_alu_op;
  logic [4:0]           idu_alu_rd;
  logic [4:0]           idu_alu_rs1;
  logic [4:0]           idu_alu_rs2;
  logic [IMM_WIDTH-1:0] idu_alu_imm;
  logic [PC_WIDTH-1:0]  idu_alu_pc;
  logic                 idu_err;

  modport slave (
    input  ifu_idu_vld, ifu_idu_ins, ifu_idu_pc, alu_idu_br_vld, idu_alu_rdy,
    output idu_ifu_rdy, idu_ifu_wfi, idu_alu_vld, idu_alu_op, idu_alu_rd,
           idu_alu_rs1, idu_alu_rs2, idu_alu_imm, idu_alu_pc, idu_err
  );

  modport master (
    output ifu_idu_vld, ifu_idu_ins, ifu_idu_pc, alu_idu_br_vld, idu_alu_rdy,
    input  idu_ifu_rdy, idu_ifu_wfi, idu_alu_vld, idu_alu_op, idu_alu_rd,
           idu_alu_rs1, idu_alu_rs2, idu_alu_imm, idu_alu_pc, idu_err
  );
endinterface

// File: rtl/idu.sv
// Purpose: decode 64-bit fixed-format instructions, run NOP/WFI/HALT locally (illegal trap under IDU_ILLEGAL_TRAP_EN).
// Latency: 1 cycle from accept to idu_alu_vld; 2-entry main+skid buffer toward the ALU.
// Backpressure: idu_ifu_rdy drops while the skid entry is occupied; registered only, no path from idu_alu_rdy.
module idu #(
  parameter int PC_WIDTH  = 32,
  parameter int IMM_WIDTH = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_vld,
  input  logic irq_wake,
  idu_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_WFI} state_t;

  typedef struct packed {
    logic [5:0]           op;
    logic [4:0]           rd;
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic [IMM_WIDTH-1:0] imm;
    logic [PC_WIDTH-1:0]  pc;
  } uop_t;

  state_t state, state_nxt;
  uop_t   dec_dat, main_dat, skid_dat;
  logic   main_vld, skid_vld;
  logic   rdy, accept, kill, take, consume;
  logic   is_fwd, is_wfi, is_halt;
  logic [5:0] op_in;
  logic   unused_rsvd;

  assign op_in       = bus.ifu_idu_ins[63:58];
  assign unused_rsvd = ^bus.ifu_idu_ins[42:32];

  always_comb begin
    dec_dat.op  = op_in;
    dec_dat.rd  = bus.ifu_idu_ins[57:53];
    dec_dat.rs1 = bus.ifu_idu_ins[52:48];
    dec_dat.rs2 = bus.ifu_idu_ins[47:43];
    dec_dat.imm = IMM_WIDTH'(bus.ifu_idu_ins[31:0]);
    dec_dat.pc  = bus.ifu_idu_pc;
  end

  assign is_fwd  = (op_in >= 6'h01) && (op_in <= 6'h05);
  assign is_wfi  = (op_in == 6'h3E);
  assign is_halt = (op_in == 6'h3F);

  assign rdy     = (state == ST_RUN) & ~skid_vld;
  assign accept  = bus.ifu_idu_vld & rdy;
  // start and flush both discard whatever is accepted in the same cycle
  assign kill    = start_vld | bus.alu_idu_br_vld;
  assign take    = accept & ~kill;
  assign consume = main_vld & bus.idu_alu_rdy;

`ifdef IDU_ILLEGAL_TRAP_EN
  logic is_ill, err_q;
  assign is_ill = ~is_fwd & ~is_wfi & ~is_halt & (op_in != 6'h00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= take & is_ill;
  end
  assign bus.idu_err = err_q;
`else
  assign bus.idu_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start_vld) begin
      state_nxt = ST_RUN;
    end else if (bus.alu_idu_br_vld) begin
      if (state == ST_WFI) state_nxt = ST_RUN;
    end else begin
      case (state)
        ST_IDLE: state_nxt = ST_IDLE;
        ST_RUN: begin
          if (accept & is_wfi)       state_nxt = ST_WFI;
          else if (accept & is_halt) state_nxt = ST_IDLE;
`ifdef IDU_ILLEGAL_TRAP_EN
          else if (accept & is_ill)  state_nxt = ST_IDLE;
`endif
        end
        ST_WFI:  if (irq_wake) state_nxt = ST_RUN;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // New op can only land while skid is empty, so a skid->main move never collides with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      main_dat <= '0;
      skid_dat <= '0;
    end else if (kill) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
    end else begin
      if (consume) begin
        main_vld <= skid_vld;
        skid_vld <= 1'b0;
        if (skid_vld) main_dat <= skid_dat;
      end
      if (take & is_fwd) begin
        if (!main_vld || consume) begin
          main_vld <= 1'b1;
          main_dat <= dec_dat;
        end else begin
          skid_vld <= 1'b1;
          skid_dat <= dec_dat;
        end
      end
    end
  end

  assign bus.idu_ifu_rdy = rdy;
  assign bus.idu_ifu_wfi = (state == ST_WFI);
  assign bus.idu_alu_vld = main_vld;
  assign bus.idu_alu_op  = main_dat.op;
  assign bus.idu_alu_rd  = main_dat.rd;
  assign bus.idu_alu_rs1 = main_dat.rs1;
  assign bus.idu_alu_rs2 = main_dat.rs2;
  assign bus.idu_alu_imm = main_dat.imm;
  assign bus.idu_alu_pc  = main_dat.pc;

endmodule

// File: tb/tb_idu.sv
// Randomized bench for idu against a queue-level reference model of decode state and the 2-deep output buffer.
// Directed prologue walks the main scenarios before a long random phase; builds with or without IDU_ILLEGAL_TRAP_EN.
module tb_idu;

  logic clk = 1'b0;
  logic rst_n;
  logic start_vld;
  logic irq_wake;

  idu_if #(.PC_WIDTH(32), .IMM_WIDTH(32)) bus ();

  idu #(.PC_WIDTH(32), .IMM_WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_vld (start_vld),
    .irq_wake  (irq_wake),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit [5:0]  op;
    bit [4:0]  rd;
    bit [4:0]  rs1;
    bit [4:0]  rs2;
    bit [31:0] imm;
    bit [31:0] pc;
  } ent_t;

  // reference model: 0 idle, 1 run, 2 wfi; q holds ops owed to the ALU, oldest first
  int   m_st;
  ent_t q[$];
  bit   exp_err;
  int   n_vec;
  int   n_bad;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("rdy", 64'(bus.idu_ifu_rdy), 64'((m_st == 1) && (q.size() < 2)));
    check("wfi", 64'(bus.idu_ifu_wfi), 64'(m_st == 2));
    check("vld", 64'(bus.idu_alu_vld), 64'(q.size() > 0));
    check("err", 64'(bus.idu_err), 64'(exp_err));
    if (q.size() > 0) begin
      check("op",  64'(bus.idu_alu_op),  64'(q[0].op));
      check("rd",  64'(bus.idu_alu_rd),  64'(q[0].rd));
      check("rs1", 64'(bus.idu_alu_rs1), 64'(q[0].rs1));
      check("rs2", 64'(bus.idu_alu_rs2), 64'(q[0].rs2));
      check("imm", 64'(bus.idu_alu_imm), 64'(q[0].imm));
      check("pc",  64'(bus.idu_alu_pc),  64'(q[0].pc));
    end
  endtask

  function automatic bit [63:0] mk(input bit [5:0] op);
    bit [63:0] w;
    w = {$urandom, $urandom};
    w[63:58] = op;
    return w;
  endfunction

  task automatic cyc(input bit st, input bit wk, input bit v, input bit [63:0] ins,
                     input bit [31:0] pc, input bit br, input bit ar);
    bit   rdy_e, acc, fwd, ill;
    bit [5:0] op;
    ent_t e;
    start_vld          = st;
    irq_wake           = wk;
    bus.ifu_idu_vld    = v;
    bus.ifu_idu_ins    = ins;
    bus.ifu_idu_pc     = pc;
    bus.alu_idu_br_vld = br;
    bus.idu_alu_rdy    = ar;

    op    = ins[63:58];
    rdy_e = (m_st == 1) && (q.size() < 2);
    acc   = v && rdy_e;
    fwd   = (op >= 6'd1) && (op <= 6'd5);
    ill   = !fwd && op != 6'h00 && op != 6'h3E && op != 6'h3F;
    exp_err = 1'b0;
    if (st) begin
      q.delete();
      m_st = 1;
    end else if (br) begin
      q.delete();
      if (m_st == 2) m_st = 1;
    end else begin
      if (q.size() > 0 && ar) void'(q.pop_front());
      if (m_st == 2 && wk) m_st = 1;
      if (acc) begin
        if (fwd) begin
          e.op = op; e.rd = ins[57:53]; e.rs1 = ins[52:48]; e.rs2 = ins[47:43];
          e.imm = ins[31:0]; e.pc = pc;
          q.push_back(e);
        end else if (op == 6'h3E) m_st = 2;
        else if (op == 6'h3F) m_st = 0;
`ifdef IDU_ILLEGAL_TRAP_EN
        else if (ill) begin
          m_st = 0;
          exp_err = 1'b1;
        end
`endif
      end
    end

    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle_cyc(input bit ar);
    cyc(1'b0, 1'b0, 1'b0, 64'd0, 32'd0, 1'b0, ar);
  endtask

  initial begin
    bit [5:0] op;
    int r;
    n_vec = 0; n_bad = 0;
    m_st = 0; exp_err = 1'b0;
    rst_n = 1'b0;
    start_vld = 1'b0; irq_wake = 1'b0;
    bus.ifu_idu_vld = 1'b0; bus.ifu_idu_ins = '0; bus.ifu_idu_pc = '0;
    bus.alu_idu_br_vld = 1'b0; bus.idu_alu_rdy = 1'b0;

    #12;
    check_outputs();
    check("rst_op",  64'(bus.idu_alu_op),  64'd0);
    check("rst_imm", 64'(bus.idu_alu_imm), 64'd0);
    check("rst_pc",  64'(bus.idu_alu_pc),  64'd0);
    rst_n = 1'b1;

    idle_cyc(1'b1);
    cyc(1'b1, 1'b0, 1'b0, 64'd0, 32'd0, 1'b0, 1'b1);

    // back-to-back ALU-imm with a free ALU
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, mk(6'h02), 32'h1000 + 32'(4 * i), 1'b0, 1'b1);
    idle_cyc(1'b1);

    // ALU stalled: two land, the third is refused, then both drain in order
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, mk(6'h01), 32'h2000 + 32'(4 * i), 1'b0, 1'b0);
    idle_cyc(1'b1);
    idle_cyc(1'b1);
    idle_cyc(1'b1);

    // WFI then wake
    cyc(1'b0, 1'b0, 1'b1, mk(6'h3E), 32'h3000, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, mk(6'h02), 32'h3004, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 64'd0, 32'd0, 1'b0, 1'b1);
    idle_cyc(1'b1);

    // flush with a full buffer, and flush colliding with an accept
    cyc(1'b0, 1'b0, 1'b1, mk(6'h03), 32'h4000, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, mk(6'h04), 32'h4004, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, mk(6'h05), 32'h4008, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, mk(6'h03), 32'h400C, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, mk(6'h05), 32'h4010, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, mk(6'h3F), 32'h4014, 1'b1, 1'b1);
    idle_cyc(1'b1);

    // illegal opcode, then HALT, then restart
    cyc(1'b0, 1'b0, 1'b1, mk(6'h2A), 32'h5000, 1'b0, 1'b1);
    idle_cyc(1'b1);
    cyc(1'b1, 1'b0, 1'b0, 64'd0, 32'd0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, mk(6'h3F), 32'h5004, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, mk(6'h02), 32'h5008, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 64'd0, 32'd0, 1'b1, 1'b1);

    for (int i = 0; i < 4000; i++) begin
      r = int'($urandom_range(0, 19));
      if (r < 12)      op = 6'($urandom_range(1, 5));
      else if (r < 14) op = 6'h00;
      else if (r == 14) op = 6'h3E;
      else if (r == 15) op = 6'h3F;
      else if (r < 18) op = 6'($urandom_range(6, 61));
      else             op = 6'($urandom_range(1, 5));
      cyc(($urandom_range(0, 39) == 0) || (m_st == 0 && $urandom_range(0, 3) == 0),
          $urandom_range(0, 7) == 0,
          $urandom_range(0, 3) != 0,
          mk(op),
          $urandom,
          $urandom_range(0, 24) == 0,
          $urandom_range(0, 2) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
